// File: rtl/branch_prediction_unit_pkg.sv
// Shared helpers for the branch predictor: saturating counter arithmetic and PC index/tag extraction.
// Pure functions with no state, so prediction and resolve paths compute identical indices.
package branch_pred_pkg;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t ctr_inc(word_t c, int bits);
        word_t mx;
        mx = (word_t'(1) << bits) - 1;
        return (c >= mx) ? mx : c + 1;
    endfunction

    function automatic word_t ctr_dec(word_t c);
        return (c == '0) ? '0 : c - 1;
    endfunction

    function automatic logic ctr_taken(word_t c, int bits);
        return c[bits-1];
    endfunction

    // Word-aligned PC: bits [1:0] never participate in indexing.
    function automatic word_t pc_index(word_t pc, int index_bits);
        return (pc >> 2) & ((word_t'(1) << index_bits) - 1);
    endfunction

    function automatic word_t pc_tag(word_t pc, int index_bits, int tag_bits);
        return (pc >> (index_bits + 2)) & ((word_t'(1) << tag_bits) - 1);
    endfunction

endpackage

// File: rtl/branch_prediction_unit_if.sv
// ID prediction and ALU resolve signals between the pipeline (master) and the predictor (slave).
interface branch_prediction_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 3
);
    logic                  id_valid;
    logic                  id_is_branch;
    logic [PC_WIDTH-1:0]   id_pc;
    logic                  id_predict_taken;
    logic [PC_WIDTH-1:0]   id_predict_target;
    logic [INDEX_BITS-1:0] id_index;

    logic                  ex_valid;
    logic                  ex_is_branch;
    logic [PC_WIDTH-1:0]   ex_pc;
    logic [INDEX_BITS-1:0] ex_index;
    logic                  ex_pred_taken;
    logic [PC_WIDTH-1:0]   ex_pred_target;
    logic                  ex_taken;
    logic [PC_WIDTH-1:0]   ex_target;

    logic                  flush;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic [15:0]           mispredict_count;

    modport master (
        output id_valid, id_is_branch, id_pc,
        output ex_valid, ex_is_branch, ex_pc, ex_index, ex_pred_taken, ex_pred_target, ex_taken, ex_target,
        input  id_predict_taken, id_predict_target, id_index, flush, redirect_pc, mispredict_count
    );

    modport slave (
        input  id_valid, id_is_branch, id_pc,
        input  ex_valid, ex_is_branch, ex_pc, ex_index, ex_pred_taken, ex_pred_target, ex_taken, ex_target,
        output id_predict_taken, id_predict_target, id_index, flush, redirect_pc, mispredict_count
    );
endinterface

// File: rtl/branch_prediction_unit_btb_array.sv
// Branch target buffer storage: combinational read, write on the clock edge, async clear of valid bits.
// Tag/target entries are not reset; a cleared valid bit is enough to hide them.
module btb_array #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 8,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    output logic                  o_rd_vld,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [PC_WIDTH-1:0]   o_rd_target,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [PC_WIDTH-1:0]   i_wr_target
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0] r_target [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

    assign o_rd_vld    = r_valid[i_rd_idx];
    assign o_rd_tag    = r_tag[i_rd_idx];
    assign o_rd_target = r_target[i_rd_idx];

endmodule

// File: rtl/branch_prediction_unit.sv
// Direction (PHT, bimodal or gshare) and target (tagged BTB) prediction in ID; resolve, flush and train in ALU.
// Prediction and flush are zero-latency combinational; training lands on the resolve edge; no backpressure.
module branch_prediction_unit
    import branch_pred_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 3,
    parameter int CTR_BITS   = 2,
    parameter int INIT_CTR   = 3,
    parameter int HIST_BITS  = 0,
    parameter int TAG_BITS   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_prediction_unit_if.slave  bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int GHR_W   = (HIST_BITS > 0) ? HIST_BITS : 1;

    logic [CTR_BITS-1:0]   r_pht [ENTRIES];
    logic [GHR_W-1:0]      r_ghr;
    logic [15:0]           r_mis_cnt;

    logic [INDEX_BITS-1:0] w_btb_idx;
    logic [INDEX_BITS-1:0] w_hist_idx;
    logic [INDEX_BITS-1:0] w_pht_idx;
    logic [TAG_BITS-1:0]   w_id_tag;
    logic [CTR_BITS-1:0]   w_ctr;
    logic                  w_rd_vld;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic [PC_WIDTH-1:0]   w_rd_target;
    logic                  w_btb_hit;
    logic                  w_resolve;
    logic                  w_mispredict;
    logic                  w_btb_wr;
    logic [INDEX_BITS-1:0] w_ex_btb_idx;
    logic [TAG_BITS-1:0]   w_ex_tag;

    assign w_btb_idx  = INDEX_BITS'(pc_index(word_t'(bus.id_pc), INDEX_BITS));
    assign w_id_tag   = TAG_BITS'(pc_tag(word_t'(bus.id_pc), INDEX_BITS, TAG_BITS));
    assign w_hist_idx = (HIST_BITS > 0) ? INDEX_BITS'(r_ghr) : '0;
    assign w_pht_idx  = w_btb_idx ^ w_hist_idx;
    assign w_ctr      = r_pht[w_pht_idx];
    assign w_btb_hit  = w_rd_vld & (w_rd_tag == w_id_tag);

    // A taken counter without a known target cannot redirect fetch, so it falls back to not-taken.
    assign bus.id_predict_taken  = reset & bus.id_valid & bus.id_is_branch
                                 & ctr_taken(word_t'(w_ctr), CTR_BITS) & w_btb_hit;
    assign bus.id_predict_target = w_btb_hit ? w_rd_target : bus.id_pc + PC_WIDTH'(4);
    assign bus.id_index          = w_pht_idx;

    assign w_resolve    = bus.ex_valid & bus.ex_is_branch;
    assign w_mispredict = (bus.ex_taken != bus.ex_pred_taken)
                        | (bus.ex_taken & bus.ex_pred_taken & (bus.ex_target != bus.ex_pred_target));

    assign bus.flush            = reset & w_resolve & w_mispredict;
    assign bus.redirect_pc      = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_WIDTH'(4);
    assign bus.mispredict_count = r_mis_cnt;

    assign w_btb_wr     = w_resolve & bus.ex_taken;
    assign w_ex_btb_idx = INDEX_BITS'(pc_index(word_t'(bus.ex_pc), INDEX_BITS));
    assign w_ex_tag     = TAG_BITS'(pc_tag(word_t'(bus.ex_pc), INDEX_BITS, TAG_BITS));

    btb_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .PC_WIDTH   (PC_WIDTH)
    ) u_btb (
        .clk         (clk),
        .rst_n       (reset),
        .i_rd_idx    (w_btb_idx),
        .o_rd_vld    (w_rd_vld),
        .o_rd_tag    (w_rd_tag),
        .o_rd_target (w_rd_target),
        .i_wr_en     (w_btb_wr),
        .i_wr_idx    (w_ex_btb_idx),
        .i_wr_tag    (w_ex_tag),
        .i_wr_target (bus.ex_target)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CTR_BITS'(INIT_CTR);
            end
        end else if (w_resolve) begin
            r_pht[bus.ex_index] <= bus.ex_taken
                                 ? CTR_BITS'(ctr_inc(word_t'(r_pht[bus.ex_index]), CTR_BITS))
                                 : CTR_BITS'(ctr_dec(word_t'(r_pht[bus.ex_index])));
        end
    end

    // History is committed only at resolve, so a flushed wrong-path branch never pollutes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ghr <= '0;
        end else if (w_resolve) begin
            r_ghr <= GHR_W'({r_ghr, bus.ex_taken});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mis_cnt <= '0;
        end else if (w_resolve && w_mispredict && (r_mis_cnt != 16'hFFFF)) begin
            r_mis_cnt <= r_mis_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Scoreboard bench: a bimodal and a gshare (2-bit history) predictor share one stimulus stream,
// each checked against its own table-level reference model.
module tb_branch_prediction_unit;

    localparam int PCW = 32;
    localparam int IB  = 3;
    localparam int NE  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_prediction_unit_if #(.PC_WIDTH(PCW), .INDEX_BITS(IB)) bus0 ();
    branch_prediction_unit_if #(.PC_WIDTH(PCW), .INDEX_BITS(IB)) bus1 ();

    branch_prediction_unit #(.PC_WIDTH(PCW), .INDEX_BITS(IB), .CTR_BITS(2), .INIT_CTR(3),
                             .HIST_BITS(0), .TAG_BITS(8))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));

    branch_prediction_unit #(.PC_WIDTH(PCW), .INDEX_BITS(IB), .CTR_BITS(2), .INIT_CTR(3),
                             .HIST_BITS(2), .TAG_BITS(8))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // stimulus
    logic        s_id_valid, s_id_is_branch;
    logic [31:0] s_id_pc;
    logic        s_ex_valid, s_ex_is_branch, s_ex_pred_taken, s_ex_taken;
    logic [31:0] s_ex_pc, s_ex_pred_target, s_ex_target;
    logic [2:0]  s_ex_index;

    // reference model: d=0 bimodal, d=1 gshare
    int unsigned m_ctr  [2][NE];
    bit          m_bv   [2][NE];
    int unsigned m_btag [2][NE];
    logic [31:0] m_btgt [2][NE];
    int unsigned m_ghr  [2];
    int unsigned m_cnt  [2];

    typedef struct {
        int          d;
        logic        pt;
        logic [31:0] tgt;
        logic [2:0]  idx;
        logic        fl;
        logic [31:0] rpc;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, act, exp);
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NE; i++) begin
                m_ctr[d][i] = 3;
                m_bv[d][i]  = 0;
            end
            m_ghr[d] = 0;
            m_cnt[d] = 0;
        end
    endfunction

    function automatic bit model_mispredict();
        return (s_ex_taken != s_ex_pred_taken) ||
               (s_ex_taken && s_ex_pred_taken && (s_ex_target != s_ex_pred_target));
    endfunction

    function automatic exp_t model_expect(int d);
        exp_t        e;
        int unsigned slot = (s_id_pc / 4) % NE;
        int unsigned tag  = (s_id_pc / 32) % 256;
        int unsigned pidx = slot ^ m_ghr[d];
        bit          hit  = m_bv[d][slot] && (m_btag[d][slot] == tag);
        logic [31:0] nxt;
        e.d   = d;
        e.idx = 3'(pidx);
        e.pt  = reset && s_id_valid && s_id_is_branch && (m_ctr[d][pidx] >= 2) && hit;
        nxt   = s_id_pc + 32'd4;
        e.tgt = hit ? m_btgt[d][slot] : nxt;
        e.fl  = reset && s_ex_valid && s_ex_is_branch && model_mispredict();
        nxt   = s_ex_pc + 32'd4;
        e.rpc = s_ex_taken ? s_ex_target : nxt;
        e.cnt = 16'(m_cnt[d]);
        return e;
    endfunction

    function automatic void model_update(int d);
        int unsigned slot;
        if (!(s_ex_valid && s_ex_is_branch)) return;
        if (s_ex_taken) begin
            if (m_ctr[d][s_ex_index] < 3) m_ctr[d][s_ex_index]++;
            slot = (s_ex_pc / 4) % NE;
            m_bv[d][slot]   = 1;
            m_btag[d][slot] = (s_ex_pc / 32) % 256;
            m_btgt[d][slot] = s_ex_target;
        end else if (m_ctr[d][s_ex_index] > 0) begin
            m_ctr[d][s_ex_index]--;
        end
        if (d == 1) m_ghr[d] = ((m_ghr[d] * 2) + (s_ex_taken ? 1 : 0)) % 4;
        if (model_mispredict() && m_cnt[d] < 65535) m_cnt[d]++;
    endfunction

    task automatic apply();
        bus0.id_valid = s_id_valid;       bus1.id_valid = s_id_valid;
        bus0.id_is_branch = s_id_is_branch; bus1.id_is_branch = s_id_is_branch;
        bus0.id_pc = s_id_pc;             bus1.id_pc = s_id_pc;
        bus0.ex_valid = s_ex_valid;       bus1.ex_valid = s_ex_valid;
        bus0.ex_is_branch = s_ex_is_branch; bus1.ex_is_branch = s_ex_is_branch;
        bus0.ex_pc = s_ex_pc;             bus1.ex_pc = s_ex_pc;
        bus0.ex_index = s_ex_index;       bus1.ex_index = s_ex_index;
        bus0.ex_pred_taken = s_ex_pred_taken; bus1.ex_pred_taken = s_ex_pred_taken;
        bus0.ex_pred_target = s_ex_pred_target; bus1.ex_pred_target = s_ex_pred_target;
        bus0.ex_taken = s_ex_taken;       bus1.ex_taken = s_ex_taken;
        bus0.ex_target = s_ex_target;     bus1.ex_target = s_ex_target;
    endtask

    // Called right after a negedge with s_* set: predict, then let the clock edge train the model.
    task automatic step();
        apply();
        #1;
        if (!reset) model_reset();
        sb_q.push_back(model_expect(0));
        sb_q.push_back(model_expect(1));
        @(posedge clk);
        if (reset) begin
            model_update(0);
            model_update(1);
        end
        @(negedge clk);
    endtask

    task automatic set_id(logic v, logic [31:0] pc);
        s_id_valid = v; s_id_is_branch = v; s_id_pc = pc;
    endtask

    task automatic set_ex(logic v, logic [31:0] pc, logic [2:0] idx, logic pt,
                          logic [31:0] ptgt, logic t, logic [31:0] tgt);
        s_ex_valid = v; s_ex_is_branch = v; s_ex_pc = pc; s_ex_index = idx;
        s_ex_pred_taken = pt; s_ex_pred_target = ptgt; s_ex_taken = t; s_ex_target = tgt;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [6];
        pool[0] = 32'h40; pool[1] = 32'h60; pool[2] = 32'h44;
        pool[3] = 32'h80; pool[4] = 32'hFFFF_FFFC; pool[5] = {$urandom_range(0, 32'h3FFF), 2'b00};
        return pool[$urandom_range(0, 5)];
    endfunction

    function automatic exp_t actual(int d);
        exp_t a;
        a.d = d;
        if (d == 0) begin
            a.pt = bus0.id_predict_taken; a.tgt = bus0.id_predict_target; a.idx = bus0.id_index;
            a.fl = bus0.flush; a.rpc = bus0.redirect_pc; a.cnt = bus0.mispredict_count;
        end else begin
            a.pt = bus1.id_predict_taken; a.tgt = bus1.id_predict_target; a.idx = bus1.id_index;
            a.fl = bus1.flush; a.rpc = bus1.redirect_pc; a.cnt = bus1.mispredict_count;
        end
        return a;
    endfunction

    // monitor: outputs are live every cycle, compared mid-low-phase
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = actual(e.d);
                chk("predict_taken", e.d, 32'(a.pt), 32'(e.pt));
                if (e.pt || !a.pt) chk("predict_target", e.d, a.tgt, e.tgt);
                chk("id_index", e.d, 32'(a.idx), 32'(e.idx));
                chk("flush", e.d, 32'(a.fl), 32'(e.fl));
                if (e.fl) chk("redirect_pc", e.d, a.rpc, e.rpc);
                chk("mispredict_count", e.d, 32'(a.cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        reset = 1'b0;
        set_id(0, 0);
        set_ex(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        // reset held with a mispredicting resolve present: no flush, no prediction
        set_id(1, 32'h40);
        set_ex(1, 32'h40, 0, 0, 0, 1, 32'h80);
        step();
        step();
        reset = 1'b1;
        set_ex(0, 0, 0, 0, 0, 0, 0);
        step();                                         // BTB miss, target 0x44
        set_ex(1, 32'h40, 0, 0, 32'h44, 1, 32'h80);
        step();                                         // flush, redirect 0x80
        set_ex(0, 0, 0, 0, 0, 0, 0);
        step();                                         // now predicts taken to 0x80
        for (int i = 0; i < 4; i++) begin
            set_ex(1, 32'h40, 0, 0, 32'h44, 0, 32'h80);  // counter 3->2->1->0->0
            step();
        end
        set_ex(0, 0, 0, 0, 0, 0, 0);
        step();
        // aliasing: 0x60 shares slot 0 with 0x40 under a different tag
        set_ex(1, 32'h40, 0, 1, 32'h80, 1, 32'h80);
        step();
        set_ex(1, 32'h60, 0, 0, 32'h64, 1, 32'hC0);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        step();
        // history: two taken resolves, gshare ID index for 0x40 becomes 3
        set_ex(1, 32'h40, 3, 1, 32'h80, 1, 32'h80);
        step();
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        step();
        // PC wrap on both fall-through paths
        set_id(1, 32'hFFFF_FFFC);
        set_ex(1, 32'hFFFF_FFFC, 7, 1, 32'h100, 0, 32'h100);
        step();
        set_id(0, 32'h40);
        set_ex(1, 32'h100, 2, 1, 32'h200, 1, 32'h204);  // target mispredict only
        step();

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] tgt;
            reset = ($urandom_range(0, 99) != 0);
            set_id($urandom_range(0, 3) != 0, pick_pc());
            s_id_is_branch = s_id_valid && ($urandom_range(0, 7) != 0);
            tgt = pick_pc();
            set_ex($urandom_range(0, 2) != 0, pick_pc(), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? tgt : pick_pc(),
                   1'($urandom_range(0, 1)), tgt);
            s_ex_is_branch = s_ex_valid && ($urandom_range(0, 7) != 0);
            step();
        end
        reset = 1'b1;

        // drive the counter to saturation, then reset mid-stream
        set_id(1, 32'h40);
        set_ex(1, 32'h40, 0, 1, 32'h80, 0, 32'h80);
        for (int n = 0; n < 65540; n++) step();
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_prediction_unit.md
Name: branch_prediction_unit

Overview:
- Parametrised successor to the 8-entry 2-bit hazard predictor.
- Predicts direction and target for branches in ID using a pattern history table (PHT) of saturating counters, optional gshare indexing, and a tagged branch target buffer (BTB).
- Resolves branches in the ALU stage and raises flush/redirect on a direction or target mispredict.
- Sits between the ID/ALU pipeline registers and the PC-select mux.

Parameters:
PC_WIDTH, 32, program counter width
INDEX_BITS, 3, log2 of PHT and BTB entry count
CTR_BITS, 2, saturating counter width (>=1)
INIT_CTR, 3, counter reset value (3 = strongly taken with CTR_BITS=2)
HIST_BITS, 0, global history length; 0 = bimodal, >0 = gshare (must be <= INDEX_BITS)
TAG_BITS, 8, BTB tag width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
id_valid  in  1  ID stage holds a valid instruction
id_is_branch  in  1  ID instruction is a conditional branch
id_pc  in  PC_WIDTH  ID instruction PC
id_predict_taken  out  1  predicted taken
id_predict_target  out  PC_WIDTH  predicted target (valid when id_predict_taken)
id_index  out  INDEX_BITS  PHT index used; pipelined down to ex_index
ex_valid  in  1  ALU stage holds a valid instruction
ex_is_branch  in  1  ALU instruction is a conditional branch
ex_pc  in  PC_WIDTH  ALU instruction PC
ex_index  in  INDEX_BITS  PHT index captured at prediction
ex_pred_taken  in  1  prediction made in ID
ex_pred_target  in  PC_WIDTH  target predicted in ID
ex_taken  in  1  actual outcome
ex_target  in  PC_WIDTH  actual target
flush  out  1  squash IF/ID
redirect_pc  out  PC_WIDTH  correct next PC when flush=1
mispredict_count  out  16  saturating mispredict counter

Behaviour:
- Reset (reset=0, async): all PHT counters = INIT_CTR; BTB valid bits = 0; GHR = 0; mispredict_count = 0. While reset=0: flush = 0, id_predict_taken = 0.
- Indexing:
  - bimodal index = id_pc[INDEX_BITS+1:2];
  - gshare index = that value XOR {zeros, GHR}.
  - BTB index is always id_pc[INDEX_BITS+1:2].
  - tag = id_pc[INDEX_BITS+2 +: TAG_BITS].
- Prediction (combinational, zero latency):
  - btb_hit = valid & tag match.
  - id_predict_taken = id_valid & id_is_branch & ctr MSB & btb_hit.
  - Counter taken with BTB miss predicts not-taken.
  - id_predict_target = BTB target on hit, else id_pc+4.
- Resolve (resolve = ex_valid & ex_is_branch):
  - mispredict = (ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target).
  - flush = resolve & mispredict, combinational in the same cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - flush = 0 when not resolving.
- Update (registered, on the clk edge where resolve = 1):
  - PHT[ex_index] +1 if taken, saturating at 2^CTR_BITS-1; -1 if not taken, saturating at 0.
  - If taken: BTB entry for ex_pc is written with valid = 1, tag, and ex_target. This allocates or overwrites on tag conflict.
  - If not taken: BTB is unchanged.
  - GHR = {GHR[HIST_BITS-2:0], ex_taken}. GHR is non-speculative and only updated at resolve.
  - mispredict_count increments on mispredict and saturates at 16'hFFFF.
- Same-cycle read/write of one entry: ID reads the pre-update value (no bypass).
- PC arithmetic is modulo 2^PC_WIDTH; pc+4 wraps.
- Reset asserted mid-operation discards the pending update. The first edge after release performs no update unless resolve = 1.

Decomposition:
- Package branch_pred_pkg holds:
  - counter saturation increment/decrement and taken-threshold functions;
  - the index/tag extraction functions, shared by ID and ALU.
- One sub-module, btb_array: tag/target/valid storage with one combinational read port and one registered write port, async active-low clear of valid bits.

Test Plan:
- Reset then ID branch at pc 0x40 -> id_predict_taken=0 (BTB miss), id_predict_target=0x44.
- Resolve taken pc 0x40 -> 0x80 with ex_pred_taken=0 -> flush=1 and redirect_pc=0x80 same cycle. Next cycle ID at 0x40 -> predict taken, target 0x80.
- Defaults: resolve pc 0x40 not-taken four times -> counter 3->2->1->0->0 (saturates). Prediction stays not-taken and BTB entry remains valid.
- Aliasing: pc 0x40 then pc 0x60 (same index, different tag), both taken -> second overwrites. ID at 0x40 misses BTB -> predicts not-taken.
- HIST_BITS=2: resolve taken, taken -> GHR=2'b11. ID pc 0x40 -> id_index = 3'b000^3'b011 = 3'b011.
- 65536+ forced mispredicts -> mispredict_count holds 16'hFFFF. Assert reset mid-stream -> count=0 and flush=0 immediately.
